// File: rtl/sdram_write_arbiter_if.sv
// Client and controller signals of the SDRAM write arbiter.
// slave: the arbiter itself; master: the clients plus the SDRAM controller.
interface sdram_write_arbiter_if;
  logic        c0_wr_request, c1_wr_request;
  logic [22:0] c0_wr_address, c1_wr_address;
  logic [31:0] c0_wr_data, c1_wr_data;
  logic [3:0]  c0_wr_mask, c1_wr_mask;
  logic [8:0]  c0_wr_burst_length, c1_wr_burst_length;
  logic        c0_wr_done, c1_wr_done;
  logic        c0_busy, c1_busy;
  logic [22:0] wr_address;
  logic        wr_request;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [8:0]  wr_burst_length;
  logic        wr_done;
  logic        grant;

  modport slave (
    input  c0_wr_request, c1_wr_request, c0_wr_address, c1_wr_address,
           c0_wr_data, c1_wr_data, c0_wr_mask, c1_wr_mask,
           c0_wr_burst_length, c1_wr_burst_length, wr_done,
    output c0_wr_done, c1_wr_done, c0_busy, c1_busy, wr_address, wr_request,
           wr_data, wr_mask, wr_burst_length, grant
  );

  modport master (
    output c0_wr_request, c1_wr_request, c0_wr_address, c1_wr_address,
           c0_wr_data, c1_wr_data, c0_wr_mask, c1_wr_mask,
           c0_wr_burst_length, c1_wr_burst_length, wr_done,
    input  c0_wr_done, c1_wr_done, c0_busy, c1_busy, wr_address, wr_request,
           wr_data, wr_mask, wr_burst_length, grant
  );
endinterface

// File: rtl/sdram_write_arbiter.sv
// Two-client SDRAM write port arbiter (terminal stream = client 0, font loader = client 1).
// Define WR_ARBITER_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to client 0.
module sdram_write_arbiter #(
  parameter logic [8:0] BURST_MAX = 9'd256
) (
  input logic                  clk,
  input logic                  reset,
  sdram_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0][22:0] addr_q, addr_d;
  logic [1:0][31:0] data_q, data_d;
  logic [1:0][3:0]  mask_q, mask_d;
  logic [1:0][8:0]  burst_q, burst_d;

  logic             wr_request_q, wr_request_d;
  logic [22:0]      wr_address_q, wr_address_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [3:0]       wr_mask_q, wr_mask_d;
  logic [8:0]       wr_burst_q, wr_burst_d;
  logic             grant_q, grant_d;
  logic [1:0]       done_q, done_d;

  logic [1:0]       req;
  logic [1:0][22:0] req_addr;
  logic [1:0][31:0] req_data;
  logic [1:0][3:0]  req_mask;
  logic [1:0][8:0]  req_burst;
  logic             win;

  function automatic logic [8:0] clamp_burst(input logic [8:0] b);
    if (b == 9'd0)      return 9'd1;
    if (b > BURST_MAX)  return BURST_MAX;
    return b;
  endfunction

  always_comb begin
    req       = {bus.c1_wr_request, bus.c0_wr_request};
    req_addr  = {bus.c1_wr_address, bus.c0_wr_address};
    req_data  = {bus.c1_wr_data, bus.c0_wr_data};
    req_mask  = {bus.c1_wr_mask, bus.c0_wr_mask};
    req_burst = {bus.c1_wr_burst_length, bus.c0_wr_burst_length};
  end

`ifdef WR_ARBITER_ROUND_ROBIN_EN
  // Under contention the client that did not own the last grant goes next.
  always_comb win = (&pending_q) ? ~grant_q : ~pending_q[0];
`else
  always_comb win = ~pending_q[0];
`endif

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    burst_d      = burst_q;
    wr_request_d = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    wr_mask_d    = wr_mask_q;
    wr_burst_d   = wr_burst_q;
    grant_d      = grant_q;
    done_d       = 2'b00;

    // A request while already pending is a protocol violation and is dropped.
    for (int i = 0; i < 2; i++) begin
      if (req[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        addr_d[i]    = req_addr[i];
        data_d[i]    = req_data[i];
        mask_d[i]    = req_mask[i];
        burst_d[i]   = clamp_burst(req_burst[i]);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          wr_request_d = 1'b1;
          wr_address_d = addr_q[win];
          wr_data_d    = data_q[win];
          wr_mask_d    = mask_q[win];
          wr_burst_d   = burst_q[win];
          grant_d      = win;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.wr_done) begin
          done_d[grant_q]    = 1'b1;
          pending_d[grant_q] = 1'b0;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 2'b00;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      burst_q      <= '0;
      wr_request_q <= 1'b0;
      wr_address_q <= 23'd0;
      wr_data_q    <= 32'd0;
      wr_mask_q    <= 4'hF;
      wr_burst_q   <= 9'd1;
      grant_q      <= 1'b1;
      done_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      burst_q      <= burst_d;
      wr_request_q <= wr_request_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      wr_mask_q    <= wr_mask_d;
      wr_burst_q   <= wr_burst_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
    end
  end

  assign bus.wr_request      = wr_request_q;
  assign bus.wr_address      = wr_address_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.wr_mask         = wr_mask_q;
  assign bus.wr_burst_length = wr_burst_q;
  assign bus.grant           = grant_q;
  assign bus.c0_wr_done      = done_q[0];
  assign bus.c1_wr_done      = done_q[1];
  assign bus.c0_busy         = pending_q[0];
  assign bus.c1_busy         = pending_q[1];
endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Directed bench for sdram_write_arbiter: vector table of single transactions plus
// hand sequences for contention, overlap, stray done, simultaneous events and reset.
module tb_sdram_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

`ifdef WR_ARBITER_ROUND_ROBIN_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  sdram_write_arbiter_if bus();
  sdram_write_arbiter #(.BURST_MAX(9'd256)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [22:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [8:0]  bin;
    int          lat;
    logic [8:0]  bexp;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int c, input logic [22:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [8:0] b);
    if (c == 0) begin
      bus.c0_wr_request = 1'b1; bus.c0_wr_address = a; bus.c0_wr_data = d;
      bus.c0_wr_mask = m; bus.c0_wr_burst_length = b;
    end else begin
      bus.c1_wr_request = 1'b1; bus.c1_wr_address = a; bus.c1_wr_data = d;
      bus.c1_wr_mask = m; bus.c1_wr_burst_length = b;
    end
  endtask

  // Drop the pulse and scramble the fields so only latched values can be forwarded.
  task automatic clr_req();
    bus.c0_wr_request = 1'b0; bus.c1_wr_request = 1'b0;
    bus.c0_wr_address = 23'h55555; bus.c1_wr_address = 23'h2AAAA;
    bus.c0_wr_data = 32'h0BAD0BAD; bus.c1_wr_data = 32'h0BAD0BAD;
    bus.c0_wr_mask = 4'h0; bus.c1_wr_mask = 4'h0;
    bus.c0_wr_burst_length = 9'd7; bus.c1_wr_burst_length = 9'd7;
  endtask

  function automatic logic done_of(input int c);
    return (c == 0) ? bus.c0_wr_done : bus.c1_wr_done;
  endfunction

  function automatic logic busy_of(input int c);
    return (c == 0) ? bus.c0_busy : bus.c1_busy;
  endfunction

  task automatic do_txn(input string n, input vec_t v);
    set_req(v.c, v.addr, v.data, v.mask, v.bin);
    step(); clr_req();
    chk({n, " busy T+1"}, 32'(busy_of(v.c)), 32'd1);
    chk({n, " no req T+1"}, 32'(bus.wr_request), 32'd0);
    step();
    chk({n, " wr_request T+2"}, 32'(bus.wr_request), 32'd1);
    chk({n, " addr"}, 32'(bus.wr_address), 32'(v.addr));
    chk({n, " data"}, bus.wr_data, v.data);
    chk({n, " mask"}, 32'(bus.wr_mask), 32'(v.mask));
    chk({n, " burst"}, 32'(bus.wr_burst_length), 32'(v.bexp));
    chk({n, " grant"}, 32'(bus.grant), 32'(v.c));
    for (int k = 0; k < v.lat; k++) step();
    chk({n, " req pulse ends"}, 32'(bus.wr_request), 32'd0);
    chk({n, " addr held"}, 32'(bus.wr_address), 32'(v.addr));
    bus.wr_done = 1'b1;
    step(); bus.wr_done = 1'b0;
    chk({n, " done D+1"}, 32'(done_of(v.c)), 32'd1);
    chk({n, " other done D+1"}, 32'(done_of(1 - v.c)), 32'd0);
    chk({n, " busy drop D+1"}, 32'(busy_of(v.c)), 32'd0);
    step();
    chk({n, " done one cycle"}, 32'(done_of(v.c)), 32'd0);
  endtask

  // Both clients request in the same cycle; `first` is the expected initial winner.
  task automatic contend(input string n, input int first);
    logic [22:0] a [2];
    int second;
    a[0] = 23'h000A00; a[1] = 23'h000B00;
    second = 1 - first;
    set_req(0, a[0], 32'h0000C0C0, 4'hF, 9'd4);
    set_req(1, a[1], 32'h0000C1C1, 4'h3, 9'd8);
    step(); clr_req();
    chk({n, " both busy"}, 32'({bus.c1_busy, bus.c0_busy}), 32'h3);
    step();
    chk({n, " first req"}, 32'(bus.wr_request), 32'd1);
    chk({n, " first addr"}, 32'(bus.wr_address), 32'(a[first]));
    chk({n, " first grant"}, 32'(bus.grant), 32'(first));
    step();
    bus.wr_done = 1'b1;
    step(); bus.wr_done = 1'b0;
    chk({n, " first done"}, 32'(done_of(first)), 32'd1);
    chk({n, " second still busy"}, 32'(busy_of(second)), 32'd1);
    chk({n, " no req D+1"}, 32'(bus.wr_request), 32'd0);
    step();
    chk({n, " second req D+2"}, 32'(bus.wr_request), 32'd1);
    chk({n, " second addr"}, 32'(bus.wr_address), 32'(a[second]));
    chk({n, " second grant"}, 32'(bus.grant), 32'(second));
    step();
    bus.wr_done = 1'b1;
    step(); bus.wr_done = 1'b0;
    chk({n, " second done"}, 32'(done_of(second)), 32'd1);
    step();
  endtask

  initial begin
    int dones;
    vecs[0] = '{0, 23'h000140, 32'h12345678, 4'hF, 9'd1,   5, 9'd1};
    vecs[1] = '{1, 23'h000200, 32'hA5A5A5A5, 4'h3, 9'd0,   1, 9'd1};
    vecs[2] = '{1, 23'h7FFFFC, 32'hDEADBEEF, 4'h8, 9'd300, 3, 9'd256};
    vecs[3] = '{0, 23'h000010, 32'h00000000, 4'h5, 9'd256, 2, 9'd256};
    vecs[4] = '{0, 23'h123458, 32'hFFFFFFFF, 4'hA, 9'd257, 1, 9'd256};
    vecs[5] = '{1, 23'h000004, 32'h00000001, 4'h1, 9'd255, 4, 9'd255};

    reset = 1'b1; bus.wr_done = 1'b0; clr_req();
    step(); step();
    reset = 1'b0;
    chk("rst wr_request", 32'(bus.wr_request), 32'd0);
    chk("rst wr_address", 32'(bus.wr_address), 32'd0);
    chk("rst wr_data", bus.wr_data, 32'd0);
    chk("rst wr_mask", 32'(bus.wr_mask), 32'hF);
    chk("rst burst", 32'(bus.wr_burst_length), 32'd1);
    chk("rst grant", 32'(bus.grant), 32'd1);
    chk("rst busy/done", 32'({bus.c1_busy, bus.c0_busy, bus.c1_wr_done, bus.c0_wr_done}), 32'd0);
    step();

    for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

    // Contention from grant=1: client 0 first in both modes.
    contend("contend_g1", 0);
    do_txn("lone_c0", vecs[3]);
    // Contention from grant=0: round-robin hands it to client 1.
    contend("contend_g0", (RR != 0) ? 1 : 0);

    // Overlap: second pulse from c0 while pending must be dropped.
    set_req(0, 23'h000000, 32'h11111111, 4'hF, 9'd2);
    step(); clr_req();
    set_req(0, 23'h000004, 32'h22222222, 4'h1, 9'd3);
    step(); clr_req();
    chk("overlap addr", 32'(bus.wr_address), 32'h0);
    chk("overlap data", bus.wr_data, 32'h11111111);
    step(); step();
    bus.wr_done = 1'b1;
    step(); bus.wr_done = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      dones += int'(bus.c0_wr_done);
      if (bus.wr_request) dones += 10;
      step();
    end
    chk("overlap single done", 32'(dones), 32'd1);

    // Stray done while idle.
    bus.wr_done = 1'b1;
    step(); bus.wr_done = 1'b0;
    chk("stray no done", 32'({bus.c1_wr_done, bus.c0_wr_done}), 32'd0);
    chk("stray no req", 32'(bus.wr_request), 32'd0);
    step();
    do_txn("after_stray", vecs[0]);

    // New request from c1 in the same cycle c0 completes.
    set_req(0, 23'h000300, 32'h33333333, 4'hF, 9'd1);
    step(); clr_req(); step(); step();
    bus.wr_done = 1'b1;
    set_req(1, 23'h000310, 32'h44444444, 4'h6, 9'd5);
    step(); bus.wr_done = 1'b0; clr_req();
    chk("simul c0 done", 32'(bus.c0_wr_done), 32'd1);
    chk("simul busy", 32'({bus.c1_busy, bus.c0_busy}), 32'h2);
    step();
    chk("simul c1 req", 32'(bus.wr_request), 32'd1);
    chk("simul c1 addr", 32'(bus.wr_address), 32'h000310);
    step();

    // Reset while c1 sits in WAIT.
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("midrst wr_request", 32'(bus.wr_request), 32'd0);
    chk("midrst addr/data", 32'(bus.wr_address) | bus.wr_data, 32'd0);
    chk("midrst mask", 32'(bus.wr_mask), 32'hF);
    chk("midrst burst", 32'(bus.wr_burst_length), 32'd1);
    chk("midrst grant", 32'(bus.grant), 32'd1);
    chk("midrst busy", 32'({bus.c1_busy, bus.c0_busy}), 32'd0);
    bus.wr_done = 1'b1;
    step(); bus.wr_done = 1'b0;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      dones += int'(bus.c0_wr_done) + int'(bus.c1_wr_done) + int'(bus.wr_request);
      step();
    end
    chk("midrst no done", 32'(dones), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
